game_ctrl: RTL



---
 rtl/game_ctrl_pkg.sv | 26 ++
 rtl/game_ctrl_score_counter.sv | 19 +
 rtl/game_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared types and defaults for the game controller.
package game_ctrl_pkg;

  localparam int unsigned X_W     = 10;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = 8;

  localparam int unsigned GOAL_LEFT_DEF   = 25;
  localparam int unsigned GOAL_RIGHT_DEF  = 610;
  localparam int unsigned WIN_SCORE_DEF   = 9;
  localparam int unsigned SERVE_TICKS_DEF = 60;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

endpackage

// File: rtl/game_ctrl_score_counter.sv
// Per-player score register with synchronous clear and increment enable.
module score_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear wins over increment; reset is synchronous active-low.
  always_ff @(posedge clk) begin
    if (!reset)      count <= '0;
    else if (clr)    count <= '0;
    else if (inc)    count <= count + W'(1);
  end

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: start, serve hold, rally, scoring and game over.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned GOAL_LEFT   = GOAL_LEFT_DEF,
  parameter int unsigned GOAL_RIGHT  = GOAL_RIGHT_DEF,
  parameter int unsigned WIN_SCORE   = WIN_SCORE_DEF,
  parameter int unsigned SERVE_TICKS = SERVE_TICKS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [X_W-1:0]     ball_x,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               ball_en,
  output logic               ball_restart,
  output logic               serve_dir,
  output logic [1:0]         winner
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               start_q;
  logic               start_evt_c;
  logic               dir_d, en_d, restart_d;
  winner_t            win_q, win_d;
  logic               p1_inc, p2_inc, clr;
  logic [SCORE_W-1:0] p1_next, p2_next;

  assign start_evt_c = start & ~start_q;
  assign p1_next     = p1_score + SCORE_W'(1);
  assign p2_next     = p2_score + SCORE_W'(1);
  assign winner      = win_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, serve counter and scoring decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = serve_dir;
    win_d   = win_q;
    p1_inc  = 1'b0;
    p2_inc  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_evt_c) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (tick) begin
          if (cnt_q == CNT_W'(SERVE_TICKS - 1)) state_d = ST_PLAY;
          else                                  cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_PLAY: begin
        if (tick) begin
          if (ball_x < X_W'(GOAL_LEFT)) begin
            p2_inc = 1'b1;
            dir_d  = 1'b0;
            if (p2_next == SCORE_W'(WIN_SCORE)) begin
              state_d = ST_OVER;
              win_d   = WIN_P2;
            end else begin
              state_d = ST_SERVE;
            end
          end else if (ball_x > X_W'(GOAL_RIGHT)) begin
            p1_inc = 1'b1;
            dir_d  = 1'b1;
            if (p1_next == SCORE_W'(WIN_SCORE)) begin
              state_d = ST_OVER;
              win_d   = WIN_P1;
            end else begin
              state_d = ST_SERVE;
            end
          end
        end
      end
      ST_OVER: begin
        if (start_evt_c) begin
          clr     = 1'b1;
          win_d   = WIN_NONE;
          state_d = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Every entry into SERVE restarts the hold count and recentres the ball.
    restart_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    if (restart_d) cnt_d = '0;
    en_d = (state_d == ST_PLAY);
  end

  // Registered outputs and housekeeping registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      start_q      <= 1'b0;
      serve_dir    <= 1'b0;
      win_q        <= WIN_NONE;
      ball_en      <= 1'b0;
      ball_restart <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      start_q      <= start;
      serve_dir    <= dir_d;
      win_q        <= win_d;
      ball_en      <= en_d;
      ball_restart <= restart_d;
    end
  end

  score_counter #(.W(SCORE_W)) u_p1 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (p1_inc),
    .count (p1_score)
  );

  score_counter #(.W(SCORE_W)) u_p2 (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (p2_inc),
    .count (p2_score)
  );

endmodule
